// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: loads a program into a single-port instruction memory, then fetches from it.
// Latency: RUN returns the instruction in the same cycle as pc. LOAD writes in the same cycle as the handshake.
// Backpressure: load_ready is high for the whole LOAD phase. It drops once the last word or the top address is written.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   load_start, run_start           phase requests, sampled only in IDLE/HALT
//   load_valid/ready/data/last      program-load stream
//   mem_addr/we/wdata, mem_rdata    single port of the instruction memory (asynchronous read)
//   stall, branch_taken/target      datapath control of the next pc
//   instruction, instr_valid, pc    fetch result to the datapath
//   load_count, load_done, halted   status
module fetch_sequencer #(
   parameter int INSTRUCTION_WIDTH = 10,
   parameter int ADDR_BITS         = 6,
   parameter logic [INSTRUCTION_WIDTH-1:0] HALT_WORD = '1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load_start,
   input  logic                         run_start,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [INSTRUCTION_WIDTH-1:0] load_data,
   input  logic                         load_last,
   output logic [ADDR_BITS-1:0]         mem_addr,
   output logic                         mem_we,
   output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
   input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
   input  logic                         stall,
   input  logic                         branch_taken,
   input  logic [ADDR_BITS-1:0]         branch_target,
   output logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         instr_valid,
   output logic [ADDR_BITS-1:0]         pc,
   output logic [ADDR_BITS:0]           load_count,
   output logic                         load_done,
   output logic                         halted
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_BITS-1:0] PC_ONE    = 1;
   localparam logic [ADDR_BITS:0]   CNT_ONE   = 1;

   state_t                 state_q;
   logic [ADDR_BITS-1:0]   pc_q;
   logic [ADDR_BITS-1:0]   wptr_q;
   logic [ADDR_BITS:0]     load_count_q;
   logic                   load_done_q;
   logic                   halted_q;

   // Memory port and datapath outputs are decoded straight from the state.
   // Outside LOAD and RUN every one of them is held at zero.
   always_comb begin
      load_ready  = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      instruction = '0;
      instr_valid = 1'b0;
      case (state_q)
         ST_LOAD: begin
            load_ready = 1'b1;
            mem_addr   = wptr_q;
            mem_we     = load_valid;
            mem_wdata  = load_data;
         end
         ST_RUN: begin
            mem_addr    = pc_q;
            instruction = mem_rdata;
            instr_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         wptr_q       <= '0;
         load_count_q <= '0;
         load_done_q  <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         load_done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_HALT: begin
               // A load request takes precedence over a run request.
               if (load_start) begin
                  state_q  <= ST_LOAD;
                  wptr_q   <= '0;
                  halted_q <= 1'b0;
               end else if (run_start) begin
                  state_q  <= ST_RUN;
                  pc_q     <= '0;
                  halted_q <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (load_valid) begin
                  // The top address ends the load even without load_last.
                  // The pointer never wraps, so earlier words are never overwritten.
                  if (load_last || (wptr_q == LAST_ADDR)) begin
                     state_q      <= ST_IDLE;
                     load_done_q  <= 1'b1;
                     load_count_q <= {1'b0, wptr_q} + CNT_ONE;
                  end else begin
                     wptr_q <= wptr_q + PC_ONE;
                  end
               end
            end
            ST_RUN: begin
               // A stall outranks everything, including a halt word on the bus.
               if (!stall) begin
                  if (mem_rdata == HALT_WORD) begin
                     state_q  <= ST_HALT;
                     halted_q <= 1'b1;
                  end else if (branch_taken) begin
                     pc_q <= branch_target;
                  end else begin
                     pc_q <= pc_q + PC_ONE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign pc         = pc_q;
   assign load_count = load_count_q;
   assign load_done  = load_done_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   localparam logic [9:0] HALT = 10'h3FF;

   logic       clk;
   logic       rst_n;
   logic       load_start, run_start;
   logic       load_valid, load_ready, load_last;
   logic [9:0] load_data;
   logic [5:0] mem_addr;
   logic       mem_we;
   logic [9:0] mem_wdata, mem_rdata;
   logic       stall, branch_taken;
   logic [5:0] branch_target;
   logic [9:0] instruction;
   logic       instr_valid;
   logic [5:0] pc;
   logic [6:0] load_count;
   logic       load_done, halted;

   fetch_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .run_start(run_start),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_last(load_last),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
      .load_count(load_count), .load_done(load_done), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory owned by the bench; every write is logged.
   logic [9:0] tb_mem [64];
   logic       mem_inited = 1'b0;
   logic [5:0] wq_addr [$];
   logic [9:0] wq_data [$];

   assign mem_rdata = tb_mem[mem_addr];

   always @(posedge clk) begin
      if (!rst_n && !mem_inited) begin
         for (int i = 0; i < 64; i++) tb_mem[i] <= '0;
         mem_inited <= 1'b1;
      end else if (mem_we) begin
         tb_mem[mem_addr] <= mem_wdata;
         wq_addr.push_back(mem_addr);
         wq_data.push_back(mem_wdata);
      end
   end

   int         total, bad;
   logic [9:0] ref_mem [64];
   logic [9:0] prog [70];
   logic [5:0] exp_pc;
   logic       exp_halted;
   logic [17:0] exp_v, obs_v;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference fetch rules: stall > halt word > branch > sequential.
   task automatic model_step(input logic s, input logic b, input logic [5:0] t);
      if (!exp_halted && !s) begin
         if (ref_mem[exp_pc] == HALT) exp_halted = 1'b1;
         else if (b)                  exp_pc = t;
         else                         exp_pc = 6'((int'(exp_pc) + 1) % 64);
      end
   endtask

   task automatic start_run();
      run_start = 1'b1;
      #1;
      tick();
      run_start  = 1'b0;
      exp_pc     = '0;
      exp_halted = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if ({pc, load_count, halted, load_done} !== 15'd0) begin
         bad++;
         $display("FAIL reset_state: pc=%0d load_count=%0d halted=%b load_done=%b, required all 0",
                  pc, load_count, halted, load_done);
      end
      total++;
      if ({load_ready, instr_valid, mem_we} !== 3'b000) begin
         bad++;
         $display("FAIL reset_handshake: ready=%b vld=%b we=%b, required 000", load_ready, instr_valid, mem_we);
      end
      total++;
      if ({instruction, mem_addr, mem_wdata} !== 26'd0) begin
         bad++;
         $display("FAIL reset_bus: instr=%h addr=%0d wdata=%h, required 0", instruction, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_load(input string name, input int n, input bit gap, input bit use_last);
      int k, exp_cnt, done_cnt, done_cyc, acc_cyc, cyc_max, errs;
      k = 0; done_cnt = 0; done_cyc = -1; acc_cyc = -5; errs = 0;
      exp_cnt = use_last ? n : ((n < 64) ? n : 64);
      wq_addr.delete();
      wq_data.delete();
      load_start = 1'b1;
      #1;
      tick();
      load_start = 1'b0;
      cyc_max = gap ? 2 * n + 6 : n + 6;
      for (int c = 0; c < cyc_max; c++) begin
         load_valid = (k < n) && (!gap || (c % 2 == 1));
         load_data  = (k < n) ? prog[k] : 10'h000;
         load_last  = use_last && (k == n - 1);
         #1;
         if (load_done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (load_ready && load_valid) begin
            k++;
            acc_cyc = c;
         end
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      #1;
      total++;
      if (k != exp_cnt) begin
         bad++;
         $display("FAIL %s_accepted: got %0d words, required %0d", name, k, exp_cnt);
      end
      total++;
      if (wq_addr.size() != exp_cnt) begin
         bad++;
         $display("FAIL %s_writes: %0d mem_we pulses, required %0d", name, wq_addr.size(), exp_cnt);
      end
      for (int i = 0; i < wq_addr.size() && i < 70; i++)
         if (wq_addr[i] !== 6'(i) || wq_data[i] !== prog[i]) errs++;
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL %s_write_content: %0d writes with wrong address/data, required 0", name, errs);
      end
      total++;
      if (load_count !== 7'(exp_cnt)) begin
         bad++;
         $display("FAIL %s_load_count: %0d, required %0d", name, load_count, exp_cnt);
      end
      total++;
      if (done_cnt != 1 || done_cyc != acc_cyc + 1) begin
         bad++;
         $display("FAIL %s_load_done: %0d pulses at cycle %0d, required 1 pulse at cycle %0d",
                  name, done_cnt, done_cyc, acc_cyc + 1);
      end
      total++;
      if ({load_ready, load_done, mem_we} !== 3'b000) begin
         bad++;
         $display("FAIL %s_back_to_idle: ready=%b done=%b we=%b, required 000", name, load_ready, load_done, mem_we);
      end
      for (int i = 0; i < exp_cnt; i++) ref_mem[i] = prog[i];
   endtask

   task automatic test_run_program();
      start_run();
      for (int c = 0; c < 8; c++) begin
         stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
         #1;
         exp_v = exp_halted ? {1'b1, 1'b0, 10'h000, exp_pc} : {1'b0, 1'b1, ref_mem[exp_pc], exp_pc};
         obs_v = {halted, instr_valid, instruction, pc};
         total++;
         if (obs_v !== exp_v || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL run_program c%0d: {halt,vld,instr,pc}=%h we=%b, required %h we=0", c, obs_v, mem_we, exp_v);
         end
         model_step(stall, branch_taken, branch_target);
         tick();
      end
      total++;
      if (halted !== 1'b1 || pc !== 6'd3) begin
         bad++;
         $display("FAIL run_program_halt: halted=%b pc=%0d, required halted=1 pc=3", halted, pc);
      end
   endtask

   task automatic test_branch_stall();
      start_run();
      for (int c = 0; c < 100; c++) begin
         stall         = (c >= 2 && c <= 4);
         branch_taken  = (c == 1) || (c == 4);
         branch_target = (c == 1) ? 6'd5 : 6'd20;
         #1;
         exp_v = exp_halted ? {1'b1, 1'b0, 10'h000, exp_pc} : {1'b0, 1'b1, ref_mem[exp_pc], exp_pc};
         obs_v = {halted, instr_valid, instruction, pc};
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL branch_stall c%0d: {halt,vld,instr,pc}=%h, required %h", c, obs_v, exp_v);
         end
         if (c == 2 || c == 5 || c == 6) begin
            total++;
            if (pc !== ((c == 6) ? 6'd6 : 6'd5)) begin
               bad++;
               $display("FAIL branch_stall_pc c%0d: pc=%0d, required %0d", c, pc, (c == 6) ? 6 : 5);
            end
         end
         if (exp_halted) break;
         model_step(stall, branch_taken, branch_target);
         tick();
      end
      stall = 1'b0; branch_taken = 1'b0;
      total++;
      if (!exp_halted) begin
         bad++;
         $display("FAIL branch_stall_timeout: halt not reached, required halt at pc=3");
      end
   endtask

   task automatic test_wrap();
      start_run();
      for (int c = 0; c < 40; c++) begin
         stall         = 1'b0;
         branch_taken  = (c == 0);
         branch_target = 6'd63;
         #1;
         exp_v = exp_halted ? {1'b1, 1'b0, 10'h000, exp_pc} : {1'b0, 1'b1, ref_mem[exp_pc], exp_pc};
         obs_v = {halted, instr_valid, instruction, pc};
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL wrap c%0d: {halt,vld,instr,pc}=%h, required %h", c, obs_v, exp_v);
         end
         if (c == 1 || c == 2) begin
            total++;
            if (pc !== ((c == 1) ? 6'd63 : 6'd0)) begin
               bad++;
               $display("FAIL wrap_pc c%0d: pc=%0d, required %0d", c, pc, (c == 1) ? 63 : 0);
            end
         end
         if (exp_halted) break;
         model_step(stall, branch_taken, branch_target);
         tick();
      end
      branch_taken = 1'b0;
      total++;
      if (!exp_halted) begin
         bad++;
         $display("FAIL wrap_timeout: halt not reached, required halt at pc=10");
      end
   endtask

   task automatic test_random_run();
      start_run();
      for (int c = 0; c < 300; c++) begin
         stall         = (c < 150) && ($urandom_range(3, 0) == 0);
         branch_taken  = (c < 150) && ($urandom_range(3, 0) == 0);
         branch_target = 6'($urandom_range(63, 0));
         #1;
         exp_v = exp_halted ? {1'b1, 1'b0, 10'h000, exp_pc} : {1'b0, 1'b1, ref_mem[exp_pc], exp_pc};
         obs_v = {halted, instr_valid, instruction, pc};
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL random_run c%0d: {halt,vld,instr,pc}=%h, required %h", c, obs_v, exp_v);
         end
         if (exp_halted && c >= 150) break;
         model_step(stall, branch_taken, branch_target);
         tick();
      end
      stall = 1'b0; branch_taken = 1'b0;
      total++;
      if (!exp_halted) begin
         bad++;
         $display("FAIL random_run_timeout: halt not reached");
      end
   endtask

   task automatic test_priority_and_abort();
      load_start = 1'b1;
      run_start  = 1'b1;
      #1;
      tick();
      load_start = 1'b0;
      run_start  = 1'b0;
      #1;
      total++;
      if ({load_ready, instr_valid, halted} !== 3'b100) begin
         bad++;
         $display("FAIL start_priority: ready=%b vld=%b halted=%b, required 100 (LOAD)", load_ready, instr_valid, halted);
      end
      load_valid = 1'b1;
      load_data  = 10'h155;
      tick();
      load_data  = 10'h0AA;
      tick();
      load_valid = 1'b0;
      rst_n      = 1'b0;
      tick();
      #1;
      total++;
      if ({load_ready, load_count, load_done, halted, pc, mem_we} !== 17'd0) begin
         bad++;
         $display("FAIL reset_mid_load: ready=%b count=%0d done=%b halted=%b pc=%0d we=%b, required all 0",
                  load_ready, load_count, load_done, halted, pc, mem_we);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (tb_mem[0] !== 10'h155 || tb_mem[1] !== 10'h0AA) begin
         bad++;
         $display("FAIL abort_keeps_words: mem0=%h mem1=%h, required 155 0aa", tb_mem[0], tb_mem[1]);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; load_start = 1'b0; run_start = 1'b0;
      load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      exp_pc = '0; exp_halted = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      for (int i = 0; i < 70; i++) prog[i] = '0;

      test_reset();

      prog[0] = 10'h001; prog[1] = 10'h002; prog[2] = 10'h003; prog[3] = HALT;
      test_load("load_gapped", 4, 1'b1, 1'b1);
      test_run_program();
      test_branch_stall();

      for (int i = 0; i < 70; i++) begin
         prog[i] = 10'($urandom_range(1023, 0));
         if (prog[i] == HALT) prog[i] = 10'h000;
      end
      prog[10] = HALT;
      test_load("load_overflow", 70, 1'b0, 1'b0);
      test_wrap();
      test_random_run();
      test_priority_and_abort();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that owns the program counter and the single port of the instruction memory (10-bit words, 64 entries).
- Sequences two phases: a LOAD phase that writes a program into memory through a valid/ready stream, and a RUN phase that fetches one instruction per cycle into the single-cycle datapath.
- Handles stall, branch redirect and a halt word.
- Sits between the boot/test-host interface, the instruction memory, and the control unit.

Parameters:
- INSTRUCTION_WIDTH, 10: instruction word width.
- ADDR_BITS, 6: memory address width; depth = 2**ADDR_BITS.
- HALT_WORD, 10'b1111111111: instruction encoding that stops fetching.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- load_start  input  1  one-cycle request to enter LOAD (sampled in IDLE/HALT).
- run_start  input  1  one-cycle request to enter RUN from pc=0 (sampled in IDLE/HALT).
- load_valid  input  1  load_data valid.
- load_ready  output  1  sequencer accepts a load word this cycle.
- load_data  input  INSTRUCTION_WIDTH  program word to write.
- load_last  input  1  qualifies the final word of the program.
- mem_addr  output  ADDR_BITS  memory address (write address in LOAD, pc in RUN).
- mem_we  output  1  memory write enable.
- mem_wdata  output  INSTRUCTION_WIDTH  memory write data.
- mem_rdata  input  INSTRUCTION_WIDTH  memory asynchronous read data.
- stall  input  1  datapath hold; pc must not advance.
- branch_taken  input  1  redirect pc next cycle.
- branch_target  input  ADDR_BITS  redirect address.
- instruction  output  INSTRUCTION_WIDTH  current instruction to the datapath.
- instr_valid  output  1  instruction is valid (RUN only).
- pc  output  ADDR_BITS  registered program counter.
- load_count  output  ADDR_BITS+1  number of words written by the last load.
- load_done  output  1  one-cycle pulse when a load completes.
- halted  output  1  high in HALT.

Behaviour:
- One clock, clk; reset is synchronous and active-low on rst_n.
- States: IDLE, LOAD, RUN, HALT.
- Reset values: state=IDLE, pc=0, internal write pointer=0, load_count=0, load_done=0, halted=0.
- Combinational outputs in IDLE: load_ready=0, mem_we=0, instr_valid=0, instruction=0, mem_addr=0, mem_wdata=0.
- Reset mid-LOAD aborts the load; words already written stay in memory; load_count=0.
- IDLE/HALT transitions:
  - load_start -> LOAD, write pointer cleared.
  - Else run_start -> RUN, pc=0.
  - Both asserted together: load_start wins.
  - Inputs are ignored in LOAD and RUN.
- LOAD:
  - load_ready=1; mem_addr=write pointer.
  - mem_we = load_valid; mem_wdata=load_data (combinational, same cycle as handshake).
  - Each accepted word increments the pointer.
  - Exit to IDLE when the accepted word has load_last=1, or when the word written is at address 2**ADDR_BITS-1 (no wrap; extra words are never accepted).
  - On exit, next cycle: load_done=1 for exactly one cycle; load_count = words accepted (1..64).
- RUN:
  - mem_addr=pc; instruction=mem_rdata (zero added latency); instr_valid=1; mem_we=0 always.
  - Next-pc priority, highest first:
    - stall: pc holds, no state change.
    - instruction==HALT_WORD: go to HALT, pc holds at the halt address.
    - branch_taken: pc=branch_target.
    - Otherwise pc=pc+1, modulo 2**ADDR_BITS (63 wraps to 0).
  - A halt word seen while stall=1 is not acted on until stall drops.
- HALT: halted=1, instr_valid=0, instruction=0, pc frozen (visible for debug).
- load_done is asserted only in the cycle after LOAD exit; deasserted everywhere else.

Test Plan:
- Reset: hold rst_n=0 two cycles, then release -> state IDLE, pc=0, load_ready=0, instr_valid=0, halted=0, load_count=0.
- Load 4 words 0x001,0x002,0x003,0x3FF with load_valid gapped every other cycle, load_last on the 4th:
  - mem_we pulses exactly 4 times at addresses 0..3 with matching data.
  - load_done pulses once; load_count=4; state IDLE.
- Run the loaded program via run_start:
  - pc sequence 0,1,2,3 with instr_valid=1.
  - HALT_WORD at address 3 -> halted=1 next cycle; pc stays 3.
- Branch and stall:
  - branch_taken=1, target=5 at pc=1 -> next pc=5.
  - stall=1 for 3 cycles at pc=5 -> pc stays 5; increments to 6 after release.
  - stall and branch together -> pc holds.
- Overflow load: stream 70 words with no load_last -> exactly 64 writes, addresses 0..63; load_ready drops after the 64th; load_count=64.
- Wrap and priority:
  - RUN from pc=63 with no branch -> pc=0.
  - load_start and run_start together in HALT -> LOAD entered.
  - rst_n=0 mid-load -> IDLE, load_count=0.
